id_hazard_stall_ctrl: RTL and testbench
=======================================

// Module: id_hazard_stall_ctrl
// PURPOSE
//  Stall/flush sequencer for the ID stage. Branches resolve in ID using the ID forwarding path, which
//  only forwards from EX/MEM. This block detects the operand hazards that path cannot cover and
//  sequences the pipeline: it holds PC and IF/ID, injects bubbles into ID/EX, flushes IF/ID on a
//  taken branch, and counts stall cycles for the debug unit.
// PARAMETERS
//  CNT_W     16  width of the stall-cycle performance counter (saturating)
// PORTS
//  clk             in   1      system clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  run_en          in   1      0 = debug freeze: hold PC and IF/ID, bubble ID/EX, FSM and counter hold
//  rs_id           in   5      rs field of instruction in ID
//  rt_id           in   5      rt field of instruction in ID
//  uses_rt_id      in   1      instruction in ID reads rt (R-type, beq/bne, sw)
//  branch_id       in   1      instruction in ID is beq/bne/jr (compares in ID)
//  branch_taken_id in   1      branch in ID resolved taken this cycle
//  rd_ex           in   5      destination register of EX instruction (rt/rd already selected)
//  reg_write_ex    in   1      EX instruction writes the register file
//  mem_read_ex     in   1      EX instruction is a load
//  rd_mem          in   5      destination register of MEM instruction
//  mem_read_mem    in   1      MEM instruction is a load
//  pc_write        out  1      1 = PC may update
//  if_id_write     out  1      1 = IF/ID may load
//  id_ex_bubble    out  1      1 = zero ID/EX control fields this cycle
//  if_id_flush     out  1      1 = clear IF/ID (taken branch, not stalled)
//  hazard_type     out  2      0 none, 1 load-use, 2 branch-on-ALU, 3 branch-on-load
//  stall_cycles    out  CNT_W  saturating count of stall cycles since reset
// BEHAVIOUR
//  - Match(r) = (r != 0) && (r == rs_id || (uses_rt_id && r == rt_id)); branch reads treat rt as used.
//  - Detection, priority high to low, evaluated only in IDLE:
//    H3 branch_id && mem_read_ex && Match(rd_ex)               -> 2 stall cycles, hazard_type=3
//    H2 branch_id && reg_write_ex && !mem_read_ex && Match(rd_ex) -> 1 stall, hazard_type=2
//    H3' branch_id && mem_read_mem && Match(rd_mem)            -> 1 stall, hazard_type=3
//    H1 !branch_id && mem_read_ex && Match(rd_ex)              -> 1 stall, hazard_type=1
//  - FSM states: IDLE, HOLD.
//    IDLE: detect=1 -> stall now (combinational, same cycle); if 2-cycle hazard go HOLD, else stay IDLE
//    (re-evaluates next cycle). HOLD: stall unconditionally, hazard_type=3, next state IDLE.
//  - Stall cycle: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 (flush suppressed).
//  - No stall: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=branch_taken_id.
//  - run_en=0 overrides all: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0,
//    hazard_type=0; state and counter frozen; HOLD resumes its remaining cycle when run_en returns.
//  - stall_cycles += 1 on every stall cycle with run_en=1; saturates at all-ones, never wraps.
//  - Reset (async, any state incl. HOLD): state=IDLE, stall_cycles=0; while rst_n=0 outputs forced
//    pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, hazard_type=0.
//  - rd=0 never causes a stall; H1 ignores rt when uses_rt_id=0 (e.g. lw after lw to same rt).
// TESTING
//  1 lw $2 in EX, add rs=2 in ID -> one cycle pc_write=0, bubble=1, hazard_type=1; next cycle clear.
//  2 lw $5 in EX, beq rs=5 in ID -> two consecutive stall cycles (IDLE then HOLD), type=3 both;
//    stall_cycles 0->2.
//  3 add $7 in EX, bne rt=7 in ID, taken -> 1 stall with if_id_flush=0; next cycle flush=1, pc_write=1.
//  4 lw $0 in EX, beq rs=0 -> no stall; addi rt=3 in ID, uses_rt_id=0, lw $3 in EX -> no stall.
//  5 case 2, drop run_en for 3 cycles during HOLD -> frozen, counter held; resume -> one more stall.
//  6 assert rst_n=0 mid-HOLD -> outputs forced immediately, counter=0, IDLE on release;
//    force CNT_W=4 and 20 stalls -> stall_cycles stays 15.

Source files
------------

// File: rtl/id_hazard_stall_ctrl.sv
// ID-stage stall/flush sequencer: detects operand hazards that the EX/MEM-only ID forwarding path
// cannot cover, holds PC and IF/ID, bubbles ID/EX, flushes on taken branches and counts stall cycles.
module id_hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             branch_id,
  input  logic             branch_taken_id,
  input  logic [4:0]       rd_ex,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic [4:0]       rd_mem,
  input  logic             mem_read_mem,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       hazard_type,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic rt_used, match_ex, match_mem;
  logic haz_load_br, haz_alu_br, haz_mem_br, haz_load_use;
  logic stall, frozen;
  logic [1:0] type_next;

  // Branches compare both operands in ID, so rt always counts as read for them.
  assign rt_used   = uses_rt_id | branch_id;
  assign match_ex  = (rd_ex  != 5'd0) && ((rd_ex  == rs_id) || (rt_used && (rd_ex  == rt_id)));
  assign match_mem = (rd_mem != 5'd0) && ((rd_mem == rs_id) || (rt_used && (rd_mem == rt_id)));

  assign haz_load_br  = branch_id  && mem_read_ex && match_ex;
  assign haz_alu_br   = branch_id  && reg_write_ex && !mem_read_ex && match_ex;
  assign haz_mem_br   = branch_id  && mem_read_mem && match_mem;
  assign haz_load_use = !branch_id && mem_read_ex && match_ex;

  always_comb begin
    stall      = 1'b0;
    type_next  = 2'd0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (haz_load_br) begin
          stall      = 1'b1;
          type_next  = 2'd3;
          state_next = HOLD;
        end else if (haz_alu_br) begin
          stall     = 1'b1;
          type_next = 2'd2;
        end else if (haz_mem_br) begin
          stall     = 1'b1;
          type_next = 2'd3;
        end else if (haz_load_use) begin
          stall     = 1'b1;
          type_next = 2'd1;
        end
      end
      HOLD: begin
        stall      = 1'b1;
        type_next  = 2'd3;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset and debug freeze both present a held pipeline with a bubble and no hazard report.
  assign frozen       = !rst_n || !run_en;
  assign pc_write     = !frozen && !stall;
  assign if_id_write  = !frozen && !stall;
  assign id_ex_bubble = frozen || stall;
  assign if_id_flush  = !frozen && !stall && branch_taken_id;
  assign hazard_type  = frozen ? 2'd0 : type_next;
  assign stall_cycles = cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else if (run_en) begin
      state_reg <= state_next;
      if (stall && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Directed bench for id_hazard_stall_ctrl: scenario tasks with hand-computed expected outputs.
module tb_id_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, run_en;
  logic [4:0] rs_id, rt_id, rd_ex, rd_mem;
  logic       uses_rt_id, branch_id, branch_taken_id, reg_write_ex, mem_read_ex, mem_read_mem;

  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [1:0]  hazard_type;
  logic [15:0] stall_cycles;
  logic        pc_write4, if_id_write4, id_ex_bubble4, if_id_flush4;
  logic [1:0]  hazard_type4;
  logic [3:0]  stall_cycles4;

  logic [5:0] obs;
  assign obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, hazard_type};

  localparam logic [5:0] O_FROZEN = 6'b001000;
  localparam logic [5:0] O_RUN    = 6'b110000;
  localparam logic [5:0] O_FLUSH  = 6'b110100;
  localparam logic [5:0] O_ST1    = 6'b001001;
  localparam logic [5:0] O_ST2    = 6'b001010;
  localparam logic [5:0] O_ST3    = 6'b001011;

  int checks = 0;
  int errors = 0;

  id_hazard_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .branch_id(branch_id), .branch_taken_id(branch_taken_id),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .rd_mem(rd_mem), .mem_read_mem(mem_read_mem),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .hazard_type(hazard_type), .stall_cycles(stall_cycles)
  );

  id_hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .branch_id(branch_id), .branch_taken_id(branch_taken_id),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .rd_mem(rd_mem), .mem_read_mem(mem_read_mem),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .id_ex_bubble(id_ex_bubble4),
    .if_id_flush(if_id_flush4), .hazard_type(hazard_type4), .stall_cycles(stall_cycles4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic tk, input logic [4:0] rde,
                        input logic rwe, input logic mre, input logic [4:0] rdm, input logic mrm);
    rs_id = rs; rt_id = rt; uses_rt_id = urt; branch_id = br; branch_taken_id = tk;
    rd_ex = rde; reg_write_ex = rwe; mem_read_ex = mre; rd_mem = rdm; mem_read_mem = mrm;
    #1;
  endtask

  task automatic test_reset();
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== O_FROZEN) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, O_FROZEN);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", stall_cycles);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== O_FLUSH) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs, O_FLUSH);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    step();
    set_in(5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST1) begin
      errors++; $display("FAIL load_use_stall: got %b expected %b", obs, O_ST1);
    end
    step();
    set_in(5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL load_use_clear: got %b expected %b", obs, O_RUN);
    end
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch_on_load();
    step();
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST3) begin
      errors++; $display("FAIL brload_idle: got %b expected %b", obs, O_ST3);
    end
    step();
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    checks++;
    if (obs !== O_ST3) begin
      errors++; $display("FAIL brload_hold: got %b expected %b", obs, O_ST3);
    end
    checks++;
    if (stall_cycles !== 16'd2) begin
      errors++; $display("FAIL brload_count_mid: got %0d expected 2", stall_cycles);
    end
    step();
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL brload_clear: got %b expected %b", obs, O_RUN);
    end
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++; $display("FAIL brload_count: got %0d expected 3", stall_cycles);
    end
    $display("test_branch_on_load done");
  endtask

  task automatic test_branch_on_alu();
    step();
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST2) begin
      errors++; $display("FAIL bralu_stall: got %b expected %b", obs, O_ST2);
    end
    step();
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0);
    checks++;
    if (obs !== O_FLUSH) begin
      errors++; $display("FAIL bralu_flush: got %b expected %b", obs, O_FLUSH);
    end
    checks++;
    if (stall_cycles !== 16'd4) begin
      errors++; $display("FAIL bralu_count: got %0d expected 4", stall_cycles);
    end
    $display("test_branch_on_alu done");
  endtask

  task automatic test_no_hazard();
    step();
    set_in(5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL zero_reg: got %b expected %b", obs, O_RUN);
    end
    set_in(5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL rt_unused: got %b expected %b", obs, O_RUN);
    end
    set_in(5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST1) begin
      errors++; $display("FAIL rt_used: got %b expected %b", obs, O_ST1);
    end
    set_in(5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    checks++;
    if (stall_cycles !== 16'd4) begin
      errors++; $display("FAIL no_hazard_count: got %0d expected 4", stall_cycles);
    end
    $display("test_no_hazard done");
  endtask

  task automatic test_freeze_hold();
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST3) begin
      errors++; $display("FAIL freeze_detect: got %b expected %b", obs, O_ST3);
    end
    step();
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if (obs !== O_FROZEN) begin
        errors++; $display("FAIL freeze_out%0d: got %b expected %b", i, obs, O_FROZEN);
      end
      checks++;
      if (stall_cycles !== 16'd5) begin
        errors++; $display("FAIL freeze_count%0d: got %0d expected 5", i, stall_cycles);
      end
    end
    step();
    run_en = 1'b1;
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== O_ST3) begin
      errors++; $display("FAIL freeze_resume: got %b expected %b", obs, O_ST3);
    end
    step();
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL freeze_after: got %b expected %b", obs, O_RUN);
    end
    checks++;
    if (stall_cycles !== 16'd6) begin
      errors++; $display("FAIL freeze_count_end: got %0d expected 6", stall_cycles);
    end
    $display("test_freeze_hold done");
  endtask

  task automatic test_reset_hold_saturate();
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== O_FROZEN) begin
      errors++; $display("FAIL midhold_reset_out: got %b expected %b", obs, O_FROZEN);
    end
    checks++;
    if (stall_cycles !== 16'd0 || stall_cycles4 !== 4'd0) begin
      errors++; $display("FAIL midhold_reset_count: got %0d/%0d expected 0/0", stall_cycles, stall_cycles4);
    end
    step();
    rst_n = 1'b1;
    set_in(5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs !== O_RUN) begin
      errors++; $display("FAIL midhold_idle: got %b expected %b", obs, O_RUN);
    end
    set_in(5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15 || i == 16) begin
        checks++;
        if (stall_cycles4 !== 4'd15) begin
          errors++; $display("FAIL sat_at_%0d: got %0d expected 15", i, stall_cycles4);
        end
      end
    end
    checks++;
    if (stall_cycles4 !== 4'd15) begin
      errors++; $display("FAIL sat_final: got %0d expected 15", stall_cycles4);
    end
    checks++;
    if (stall_cycles !== 16'd20) begin
      errors++; $display("FAIL wide_count: got %0d expected 20", stall_cycles);
    end
    $display("test_reset_hold_saturate done");
  endtask

  initial begin
    rst_n = 1'b0;
    run_en = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    test_reset();
    test_load_use();
    test_branch_on_load();
    test_branch_on_alu();
    test_no_hazard();
    test_freeze_hold();
    test_reset_hold_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
